// File: rtl/aes_ctr_feeder.sv
// aes_ctr_feeder
// Counter-mode front/back end for the pipelined AES-256 core. Issues one
// {nonce, ctr} block per cycle to the core, follows each block through the
// fixed-latency core with a valid delay line, and buffers the core results in a
// keystream FIFO. Issue is credit-limited, so a stalled consumer never causes
// a core result to be dropped.
//
// State table:
//   S_IDLE  | waiting for start; job inputs are latched on start
//   S_RUN   | issuing counter blocks while credit and remaining blocks allow
//   S_DRAIN | all blocks issued; waiting for the pipeline and FIFO to empty
//   S_FIN   | done pulse for one cycle, then back to S_IDLE
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start                  job request (sampled in S_IDLE only)
//   nonce, ctr_init        upper 96 bits and first counter value of the blocks
//   num_blocks, key_in     job length and key
//   state, key             block and key presented to the core
//   issue_valid            state carries a live block this cycle
//   core_out               core result
//   ks_data/ks_valid/ks_ready  keystream output handshake
//   busy, done             job status
module aes_ctr_feeder #(
  parameter int LATENCY    = 21,
  parameter int FIFO_DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [95:0]  nonce,
  input  logic [31:0]  ctr_init,
  input  logic [31:0]  num_blocks,
  input  logic [255:0] key_in,
  output logic [127:0] state,
  output logic [255:0] key,
  output logic         issue_valid,
  input  logic [127:0] core_out,
  output logic [127:0] ks_data,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic         busy,
  output logic         done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [95:0]        nonce_q, nonce_d;
  logic [31:0]        ctr_q, ctr_d;
  logic [31:0]        remaining_q, remaining_d;
  logic [255:0]       key_q, key_d;
  logic [127:0]       blk_q, blk_d;
  logic               issue_q, issue_d;
  logic [LATENCY-1:0] dl_q, dl_d;
  logic [CW-1:0]      in_flight_q, in_flight_d;
  logic [CW-1:0]      fifo_count_q, fifo_count_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [127:0]       mem_q [FIFO_DEPTH];

  logic               tail;
  logic               pop;
  logic [CW-1:0]      occ;
  logic [CW-1:0]      in_flight_wo;

  assign tail = dl_q[LATENCY-1];
  assign pop  = ks_valid & ks_ready;
  // Credit: every issued block owns a FIFO slot from issue until it is popped.
  assign occ  = in_flight_q + fifo_count_q;

  always_comb begin
    fsm_d        = fsm_q;
    nonce_d      = nonce_q;
    ctr_d        = ctr_q;
    remaining_d  = remaining_q;
    key_d        = key_q;
    blk_d        = blk_q;
    issue_d      = 1'b0;
    in_flight_wo = in_flight_q - CW'(tail);
    fifo_count_d = fifo_count_q + CW'(tail) - CW'(pop);
    wr_ptr_d     = wr_ptr_q + PW'(tail);
    rd_ptr_d     = rd_ptr_q + PW'(pop);

    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          nonce_d = nonce;
          key_d   = key_in;
          if (num_blocks == 32'd0) begin
            ctr_d       = ctr_init;
            remaining_d = 32'd0;
            fsm_d       = S_FIN;
          end else begin
            // The first block leaves straight from idle so it is on the core
            // inputs in the cycle right after start.
            issue_d     = 1'b1;
            blk_d       = {nonce, ctr_init};
            ctr_d       = ctr_init + 32'd1;
            remaining_d = num_blocks - 32'd1;
            fsm_d       = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (remaining_q == 32'd0) begin
          fsm_d = S_DRAIN;
        end else if (occ < CW'(FIFO_DEPTH)) begin
          issue_d     = 1'b1;
          blk_d       = {nonce_q, ctr_q};
          ctr_d       = ctr_q + 32'd1;
          remaining_d = remaining_q - 32'd1;
        end
      end
      S_DRAIN: begin
        // Look at the post-edge counts so done lands right after the last pop.
        if (in_flight_wo == '0 && fifo_count_d == '0) fsm_d = S_FIN;
      end
      S_FIN: begin
        fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase

    in_flight_d = in_flight_wo + CW'(issue_d);
    dl_d        = dl_q << 1;
    dl_d[0]     = issue_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= S_IDLE;
      nonce_q      <= '0;
      ctr_q        <= '0;
      remaining_q  <= '0;
      key_q        <= '0;
      blk_q        <= '0;
      issue_q      <= 1'b0;
      dl_q         <= '0;
      in_flight_q  <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      fsm_q        <= fsm_d;
      nonce_q      <= nonce_d;
      ctr_q        <= ctr_d;
      remaining_q  <= remaining_d;
      key_q        <= key_d;
      blk_q        <= blk_d;
      issue_q      <= issue_d;
      dl_q         <= dl_d;
      in_flight_q  <= in_flight_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Storage only; entries are qualified by the pointers and count.
  always_ff @(posedge clk) begin
    if (tail) mem_q[wr_ptr_q] <= core_out;
  end

  assign state       = blk_q;
  assign key         = key_q;
  assign issue_valid = issue_q;
  assign ks_valid    = (fifo_count_q != '0);
  assign ks_data     = ks_valid ? mem_q[rd_ptr_q] : '0;
  assign busy        = (fsm_q != S_IDLE);
  assign done        = (fsm_q == S_FIN);

endmodule

// File: tb/tb_aes_ctr_feeder.sv
// Bench for aes_ctr_feeder. The core is modelled as a pipeline of
// STATE ^ KEY[127:0]; the feeder's own STATE register counts as the first of
// the LATENCY stages, so the model adds LATENCY-1 further stages.
module tb_aes_ctr_feeder;
  localparam int LAT   = 21;
  localparam int DEPTH = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [95:0]  nonce = '0;
  logic [31:0]  ctr_init = '0;
  logic [31:0]  num_blocks = '0;
  logic [255:0] key_in = '0;
  logic [127:0] state;
  logic [255:0] key;
  logic         issue_valid;
  logic [127:0] core_out;
  logic [127:0] ks_data;
  logic         ks_valid;
  logic         ks_ready = 1'b0;
  logic         busy;
  logic         done;

  aes_ctr_feeder #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nonce(nonce), .ctr_init(ctr_init),
    .num_blocks(num_blocks), .key_in(key_in), .state(state), .key(key),
    .issue_valid(issue_valid), .core_out(core_out), .ks_data(ks_data),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [127:0] pipe [LAT-1];
  always @(posedge clk) begin
    pipe[0] <= state ^ key[127:0];
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign core_out = pipe[LAT-2];

  logic [515:0] obs;
  assign obs = {state, key, issue_valid, ks_data, ks_valid, busy, done};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] iss_q[$];
  int           iss_cyc[$];
  logic [127:0] pop_q[$];
  int           pop_cyc[$];
  int           done_cyc[$];
  int           outstanding = 0;
  int           max_out = 0;

  always @(negedge clk) begin
    if (!rst_n) outstanding = 0;
    else begin
      if (issue_valid) begin iss_q.push_back(state); iss_cyc.push_back(cyc); outstanding++; end
      if (ks_valid && ks_ready) begin pop_q.push_back(ks_data); pop_cyc.push_back(cyc); outstanding--; end
      if (done) done_cyc.push_back(cyc);
      if (outstanding > max_out) max_out = outstanding;
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f_f0e1d2c3b4a5968778695a4b3c2d1e0f;
  localparam logic [95:0]  NONCE_A = 96'h0123456789abcdef01234567;

  function automatic logic [127:0] ks_of(input logic [95:0] nn, input logic [31:0] c, input logic [255:0] k);
    logic [127:0] b;
    b = {nn, c};
    return b ^ k[127:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [95:0] nn, input logic [31:0] c0, input logic [31:0] nb,
                           input logic [255:0] k, output int t0);
    nonce = nn; ctr_init = c0; num_blocks = nb; key_in = k;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      start = ~start; ks_ready = ~ks_ready;
      nonce = {$urandom, $urandom, $urandom}; num_blocks = 32'd4;
      tick();
      n_checks++;
      if (obs !== '0) $display("FAIL reset_outputs cyc%0d: got %h want 0", i, obs); else n_pass++;
    end
    start = 1'b0; ks_ready = 1'b1;
    rst_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_basic();
    int t0, ib, pb, db, bad_c, bad_d;
    ib = iss_q.size(); pb = pop_q.size(); db = done_cyc.size();
    ks_ready = 1'b1;
    start_job(NONCE_A, 32'd0, 32'd4, KEY_A, t0);
    for (int i = 0; i < 60 && done_cyc.size() <= db; i++) tick();
    n_checks++;
    if (done_cyc.size() <= db) $display("FAIL basic_done_timeout: got no done want done"); else n_pass++;
    tick();
    n_checks++;
    if (iss_q.size() - ib !== 4) $display("FAIL basic_issue_count: got %0d want 4", iss_q.size() - ib); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (iss_cyc[ib+i] !== t0 + 1 + i || iss_q[ib+i] !== {NONCE_A, 32'(i)})
        $display("FAIL basic_issue%0d: got cyc %0d blk %h want cyc %0d blk %h", i, iss_cyc[ib+i] - t0, iss_q[ib+i], 1 + i, {NONCE_A, 32'(i)});
      else n_pass++;
    end
    n_checks++;
    if (pop_q.size() - pb !== 4) $display("FAIL basic_pop_count: got %0d want 4", pop_q.size() - pb); else n_pass++;
    bad_c = 0; bad_d = 0;
    for (int i = 0; i < 4; i++) begin
      if (pop_cyc[pb+i] !== t0 + 22 + i) bad_c++;
      if (pop_q[pb+i] !== ks_of(NONCE_A, 32'(i), KEY_A)) bad_d++;
    end
    n_checks++;
    if (bad_c !== 0) $display("FAIL basic_ks_timing: got %0d late/early want 0 (first at t+%0d, want t+22)", bad_c, pop_cyc[pb] - t0); else n_pass++;
    n_checks++;
    if (bad_d !== 0) $display("FAIL basic_ks_data: got %0d wrong blocks want 0", bad_d); else n_pass++;
    n_checks++;
    if (done_cyc[db] !== t0 + 26) $display("FAIL basic_done_cycle: got t+%0d want t+26", done_cyc[db] - t0); else n_pass++;
    n_checks++;
    if (done_cyc.size() - db !== 1) $display("FAIL basic_done_count: got %0d want 1", done_cyc.size() - db); else n_pass++;
  endtask

  task automatic test_wrap();
    int t0, ib, pb, db;
    logic [31:0] exp_c [3];
    logic [95:0] nn;
    nn = 96'hfeedface_cafebabe_deadbeef;
    exp_c[0] = 32'hffff_fffe; exp_c[1] = 32'hffff_ffff; exp_c[2] = 32'h0000_0000;
    ib = iss_q.size(); pb = pop_q.size(); db = done_cyc.size();
    ks_ready = 1'b1;
    start_job(nn, 32'hffff_fffe, 32'd3, KEY_A, t0);
    for (int i = 0; i < 60 && done_cyc.size() <= db; i++) tick();
    n_checks++;
    if (done_cyc.size() <= db) $display("FAIL wrap_done_timeout: got no done want done"); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (iss_q[ib+i] !== {nn, exp_c[i]}) $display("FAIL wrap_issue%0d: got %h want %h", i, iss_q[ib+i], {nn, exp_c[i]}); else n_pass++;
      n_checks++;
      if (pop_q[pb+i] !== ks_of(nn, exp_c[i], KEY_A)) $display("FAIL wrap_ks%0d: got %h want %h", i, pop_q[pb+i], ks_of(nn, exp_c[i], KEY_A)); else n_pass++;
    end
    tick();
  endtask

  task automatic test_backpressure();
    int t0, ib, pb, db, bad_i, bad_p;
    logic [95:0] nn;
    logic [255:0] k;
    logic [127:0] first_ks;
    nn = 96'h111122223333444455556666;
    k  = ~KEY_A;
    ib = iss_q.size(); pb = pop_q.size(); db = done_cyc.size();
    ks_ready = 1'b0;
    start_job(nn, 32'h100, 32'd100, k, t0);
    repeat (80) tick();
    n_checks++;
    if (iss_q.size() - ib !== DEPTH) $display("FAIL bp_stall_issue_count: got %0d want %0d", iss_q.size() - ib, DEPTH); else n_pass++;
    first_ks = ks_of(nn, 32'h100, k);
    n_checks++;
    if ({ks_valid, ks_data} !== {1'b1, first_ks}) $display("FAIL bp_stall_head: got %b %h want 1 %h", ks_valid, ks_data, first_ks); else n_pass++;
    tick();
    n_checks++;
    if ({ks_valid, ks_data, busy} !== {1'b1, first_ks, 1'b1}) $display("FAIL bp_stall_stable: got %b %h %b want 1 %h 1", ks_valid, ks_data, busy, first_ks); else n_pass++;
    for (int i = 0; i < 3000 && done_cyc.size() <= db; i++) begin
      ks_ready = 1'($urandom_range(0, 1));
      tick();
    end
    ks_ready = 1'b1;
    n_checks++;
    if (done_cyc.size() <= db) $display("FAIL bp_done_timeout: got no done want done"); else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (iss_q.size() - ib !== 100 || pop_q.size() - pb !== 100)
      $display("FAIL bp_counts: got issued %0d popped %0d want 100 100", iss_q.size() - ib, pop_q.size() - pb);
    else n_pass++;
    bad_i = 0; bad_p = 0;
    for (int i = 0; i < 100; i++) begin
      if (iss_q[ib+i] !== {nn, 32'h100 + 32'(i)}) bad_i++;
      if (pop_q[pb+i] !== ks_of(nn, 32'h100 + 32'(i), k)) bad_p++;
    end
    n_checks++;
    if (bad_i !== 0) $display("FAIL bp_issue_order: got %0d wrong want 0", bad_i); else n_pass++;
    n_checks++;
    if (bad_p !== 0) $display("FAIL bp_ks_order: got %0d wrong want 0", bad_p); else n_pass++;
    n_checks++;
    if (done_cyc.size() - db !== 1) $display("FAIL bp_done_count: got %0d want 1", done_cyc.size() - db); else n_pass++;
    n_checks++;
    if (max_out > DEPTH) $display("FAIL bp_overflow: got outstanding %0d want <= %0d", max_out, DEPTH); else n_pass++;
  endtask

  task automatic test_zero();
    int t0, ib, db;
    ib = iss_q.size(); db = done_cyc.size();
    ks_ready = 1'b1;
    start_job(NONCE_A, 32'd7, 32'd0, KEY_A, t0);
    n_checks++;
    if ({busy, done} !== 2'b11) $display("FAIL zero_fin: got busy %b done %b want 1 1", busy, done); else n_pass++;
    tick();
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL zero_idle: got busy %b done %b want 0 0", busy, done); else n_pass++;
    repeat (5) tick();
    n_checks++;
    if (iss_q.size() - ib !== 0) $display("FAIL zero_no_issue: got %0d want 0", iss_q.size() - ib); else n_pass++;
    n_checks++;
    if (done_cyc.size() - db !== 1 || done_cyc[db] !== t0 + 1)
      $display("FAIL zero_done: got count %0d at t+%0d want 1 at t+1", done_cyc.size() - db, done_cyc[db] - t0);
    else n_pass++;
  endtask

  task automatic test_abuse();
    int t0, tx, ib, pb, db;
    logic [95:0] nn;
    nn = 96'habcabcabcabcabcabcabcabc;
    ks_ready = 1'b1;
    ib = iss_q.size(); pb = pop_q.size(); db = done_cyc.size();
    start_job(nn, 32'd40, 32'd6, KEY_A, t0);
    tick();
    start_job(96'h0, 32'd900, 32'd99, ~KEY_A, tx);
    for (int i = 0; i < 80 && done_cyc.size() <= db; i++) tick();
    repeat (3) tick();
    n_checks++;
    if (iss_q.size() - ib !== 6 || pop_q.size() - pb !== 6 || done_cyc.size() - db !== 1)
      $display("FAIL abuse_start_ignored: got issued %0d popped %0d done %0d want 6 6 1", iss_q.size() - ib, pop_q.size() - pb, done_cyc.size() - db);
    else n_pass++;
    n_checks++;
    if (pop_q[pb+5] !== ks_of(nn, 32'd45, KEY_A)) $display("FAIL abuse_last_ks: got %h want %h", pop_q[pb+5], ks_of(nn, 32'd45, KEY_A)); else n_pass++;

    ib = iss_q.size();
    start_job(nn, 32'd0, 32'd50, KEY_A, t0);
    for (int i = 0; i < 100 && iss_q.size() - ib < 10; i++) tick();
    n_checks++;
    if (iss_q.size() - ib !== 10) $display("FAIL abuse_reach_block10: got %0d want 10", iss_q.size() - ib); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== '0) $display("FAIL abuse_reset_outputs: got %h want 0", obs); else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    ib = iss_q.size(); pb = pop_q.size(); db = done_cyc.size();
    repeat (40) tick();
    n_checks++;
    if (iss_q.size() - ib !== 0 || pop_q.size() - pb !== 0 || done_cyc.size() - db !== 0 || busy !== 1'b0)
      $display("FAIL abuse_no_stray: got issued %0d popped %0d done %0d busy %b want 0 0 0 0", iss_q.size() - ib, pop_q.size() - pb, done_cyc.size() - db, busy);
    else n_pass++;

    pb = pop_q.size(); db = done_cyc.size();
    start_job(nn, 32'd500, 32'd3, KEY_A, t0);
    for (int i = 0; i < 60 && done_cyc.size() <= db; i++) tick();
    tick();
    n_checks++;
    if (pop_q.size() - pb !== 3 || pop_cyc[pb] !== t0 + 22)
      $display("FAIL abuse_clean_job: got %0d pops first at t+%0d want 3 at t+22", pop_q.size() - pb, pop_cyc[pb] - t0);
    else n_pass++;
    n_checks++;
    if (pop_q[pb+2] !== ks_of(nn, 32'd502, KEY_A)) $display("FAIL abuse_clean_ks: got %h want %h", pop_q[pb+2], ks_of(nn, 32'd502, KEY_A)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero();
    test_abuse();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
